// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the fetch FSM state type, the default bubble encoding and the
// default instruction/address width and instruction memory depth.
package fetch_pkg;

    localparam int DEFAULT_N         = 24;
    localparam int DEFAULT_MEM_DEPTH = 1024;

    // Encoding placed into IF/ID whenever no real instruction is present.
    localparam logic [DEFAULT_N-1:0] NOP_INSTR = 24'h000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with next-PC selection and address wrap.
// Ports: clk/rst (sync, active-high), advance (take PC+1), redirect
// (take target mod MEM_DEPTH, wins over advance), target, pc (register out).
module pc_reg #(
    parameter int N         = fetch_pkg::DEFAULT_N,
    parameter int MEM_DEPTH = fetch_pkg::DEFAULT_MEM_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    input  logic         redirect,
    input  logic [N-1:0] target,
    output logic [N-1:0] pc
);

    localparam logic [N-1:0] LAST_ADDR = N'(MEM_DEPTH - 1);
    localparam logic [N-1:0] DEPTH     = N'(MEM_DEPTH);

    logic [N-1:0] seq_pc;
    logic [N-1:0] wrapped_target;
    logic [N-1:0] next_pc;

    // Sequential fetch wraps from the last memory word back to word 0.
    assign seq_pc         = (pc == LAST_ADDR) ? '0 : pc + N'(1);
    // Branch targets outside the memory fold back into it.
    assign wrapped_target = target % DEPTH;

    always_comb begin
        next_pc = pc;
        if (redirect) begin
            next_pc = wrapped_target;
        end else if (advance) begin
            next_pc = seq_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC (via pc_reg), IF/ID pipeline register and
// IDLE/RUN/HALTED control FSM. pc_out addresses a word-addressed memory whose
// data returns on instr_in in the same cycle; it lands on instr_id one edge later.
// Ports: clk, rst (sync active-high), start, halt, stall, branch_taken,
// branch_target, pc_out, instr_in, instr_id, pc_id, valid_id, running.
// Optional: define FETCH_TRACE_EN to print captured instructions and redirects.
module fetch_stage #(
    parameter int             N         = fetch_pkg::DEFAULT_N,
    parameter int             MEM_DEPTH = fetch_pkg::DEFAULT_MEM_DEPTH,
    parameter logic [N-1:0]   NOP_INSTR = N'(fetch_pkg::NOP_INSTR)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         halt,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic [N-1:0] pc_out,
    input  logic [N-1:0] instr_in,
    output logic [N-1:0] instr_id,
    output logic [N-1:0] pc_id,
    output logic         valid_id,
    output logic         running
);

    import fetch_pkg::*;

    fetch_state_t state;

    logic pc_advance;
    logic pc_redirect;

    assign running = (state == RUN);

    // halt outranks branch and stall: the PC simply freezes where it is.
    assign pc_redirect = running && !halt && branch_taken;
    assign pc_advance  = running && !halt && !branch_taken && !stall;

    pc_reg #(
        .N         (N),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .advance  (pc_advance),
        .redirect (pc_redirect),
        .target   (branch_target),
        .pc       (pc_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            instr_id <= NOP_INSTR;
            pc_id    <= '0;
            valid_id <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    instr_id <= NOP_INSTR;
                    valid_id <= 1'b0;
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (halt) begin
                        // The word fetched this cycle is dropped.
                        state    <= HALTED;
                        instr_id <= NOP_INSTR;
                        valid_id <= 1'b0;
                    end else if (branch_taken) begin
                        // Wrong-path word becomes a bubble tagged with its PC.
                        instr_id <= NOP_INSTR;
                        pc_id    <= pc_out;
                        valid_id <= 1'b0;
                    end else if (!stall) begin
                        instr_id <= instr_in;
                        pc_id    <= pc_out;
                        valid_id <= 1'b1;
                    end
                end
                HALTED: begin
                    // Only rst leaves this state; start is deliberately ignored.
                    instr_id <= NOP_INSTR;
                    valid_id <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    instr_id <= NOP_INSTR;
                    valid_id <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_TRACE_EN
    always @(posedge clk) begin
        if (!rst && running && !halt) begin
            if (branch_taken) begin
                $display("fetch: redirect pc %0d -> %0d", pc_out, branch_target % N'(MEM_DEPTH));
            end else if (!stall) begin
                $display("fetch: pc=%b instr=%b", pc_out, instr_in);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int          N     = 24;
    localparam int          DEPTH = 1024;
    localparam logic [23:0] NOP   = 24'h000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0, start = 1'b0, halt = 1'b0, stall = 1'b0, branch_taken = 1'b0;
    logic [23:0] branch_target = '0;
    logic [23:0] pc_out, instr_in, instr_id, pc_id;
    logic        valid_id, running;

    int passed = 0;
    int total  = 0;

    // Reference model: plain integers, state as 0=idle 1=run 2=halted.
    int          m_state = 0;
    int          m_pc    = 0;
    logic [23:0] m_instr = NOP;
    int          m_pc_id = 0;
    logic        m_valid = 1'b0;

    always #5 clk = ~clk;

    // Instruction memory: word k holds k + 0x100.
    assign instr_in = pc_out + 24'h100;

    fetch_stage #(
        .N         (N),
        .MEM_DEPTH (DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .halt          (halt),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_out        (pc_out),
        .instr_in      (instr_in),
        .instr_id      (instr_id),
        .pc_id         (pc_id),
        .valid_id      (valid_id),
        .running       (running)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic model_edge();
        if (rst) begin
            m_state = 0; m_pc = 0; m_instr = NOP; m_pc_id = 0; m_valid = 1'b0;
        end else if (m_state == 0) begin
            if (start) m_state = 1;
        end else if (m_state == 1) begin
            if (halt) begin
                m_state = 2; m_instr = NOP; m_valid = 1'b0;
            end else if (branch_taken) begin
                m_instr = NOP; m_pc_id = m_pc; m_valid = 1'b0;
                m_pc = int'(branch_target) % DEPTH;
            end else if (!stall) begin
                m_instr = 24'(m_pc + 'h100); m_pc_id = m_pc; m_valid = 1'b1;
                m_pc = (m_pc + 1) % DEPTH;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc_out"},   32'(pc_out),   32'(m_pc));
        check({tag, ".instr_id"}, 32'(instr_id), 32'(m_instr));
        check({tag, ".pc_id"},    32'(pc_id),    32'(m_pc_id));
        check({tag, ".valid_id"}, 32'(valid_id), 32'(m_valid));
        check({tag, ".running"},  32'(running),  32'(m_state == 1));
    endtask

    task automatic step(input string tag, input logic r, input logic s, input logic h,
                        input logic stl, input logic b, input logic [23:0] t);
        @(negedge clk);
        rst = r; start = s; halt = h; stall = stl; branch_taken = b; branch_target = t;
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    initial begin
        logic [23:0] held_instr;
        logic [23:0] held_pc_id;
        logic        held_valid;

        // Reset, including garbage on the other inputs.
        step("rst0", 1, 1, 1, 1, 1, 24'd77);
        step("rst1", 1, 0, 0, 0, 0, 24'd0);
        check("reset.pc_out",  32'(pc_out),  0);
        check("reset.instr",   32'(instr_id), 32'(NOP));
        check("reset.running", 32'(running), 0);

        // start for one cycle then sequential fetch.
        step("start", 0, 1, 0, 0, 0, 24'd0);
        check("start.valid", 32'(valid_id), 0);
        step("seq0", 0, 0, 0, 0, 0, 24'd0);
        check("seq0.instr", 32'(instr_id), 32'h100);
        step("seq1", 0, 0, 0, 0, 0, 24'd0);
        step("seq2", 0, 0, 0, 0, 0, 24'd0);
        check("seq2.instr", 32'(instr_id), 32'h102);
        check("seq2.pc_id", 32'(pc_id), 2);
        step("seq3", 0, 0, 0, 0, 0, 24'd0);
        step("seq4", 0, 0, 0, 0, 0, 24'd0);
        check("at5.pc_out", 32'(pc_out), 5);

        // Branch from PC=5 to 40.
        step("br40", 0, 0, 0, 0, 1, 24'd40);
        check("br40.pc_out", 32'(pc_out), 40);
        check("br40.valid", 32'(valid_id), 0);
        step("br40n", 0, 0, 0, 0, 0, 24'd0);
        check("br40n.pc_id", 32'(pc_id), 40);
        check("br40n.instr", 32'(instr_id), 32'h128);

        // Stall three cycles at PC=7.
        step("br7", 0, 0, 0, 0, 1, 24'd7);
        held_instr = instr_id; held_pc_id = pc_id; held_valid = valid_id;
        for (int i = 0; i < 3; i++) begin
            step("stall", 0, 0, 0, 1, 0, 24'd0);
            check("stall.pc_out", 32'(pc_out), 7);
            check("stall.instr", 32'(instr_id), 32'(held_instr));
            check("stall.pc_id", 32'(pc_id), 32'(held_pc_id));
            check("stall.valid", 32'(valid_id), 32'(held_valid));
        end
        step("resume0", 0, 0, 0, 0, 0, 24'd0);
        check("resume0.pc_id", 32'(pc_id), 7);
        step("resume1", 0, 0, 0, 0, 0, 24'd0);
        check("resume1.pc_id", 32'(pc_id), 8);

        // Wrap at the top of memory; the target itself is out of range.
        step("br2047", 0, 0, 0, 0, 1, 24'd2047);
        check("br2047.pc_out", 32'(pc_out), 1023);
        step("wrap", 0, 0, 0, 0, 0, 24'd0);
        check("wrap.pc_out", 32'(pc_out), 0);
        check("wrap.pc_id", 32'(pc_id), 1023);

        // Stall and branch together: branch wins.
        step("br3", 0, 0, 0, 0, 1, 24'd3);
        step("stbr", 0, 0, 0, 1, 1, 24'd9);
        check("stbr.pc_out", 32'(pc_out), 9);
        check("stbr.valid", 32'(valid_id), 0);

        // Halt with branch at PC=12, then start is ignored.
        step("br12", 0, 0, 0, 0, 1, 24'd12);
        step("halt", 0, 0, 1, 0, 1, 24'd99);
        check("halt.running", 32'(running), 0);
        check("halt.valid", 32'(valid_id), 0);
        check("halt.pc_out", 32'(pc_out), 12);
        check("halt.instr", 32'(instr_id), 32'(NOP));
        step("halt_start0", 0, 1, 0, 0, 0, 24'd0);
        step("halt_start1", 0, 1, 0, 0, 0, 24'd0);
        check("halt_start.pc_out", 32'(pc_out), 12);

        // Mid-run reset.
        step("rst2", 1, 0, 0, 0, 0, 24'd0);
        step("start2", 0, 1, 0, 0, 0, 24'd0);
        for (int i = 0; i < 6; i++) step("run2", 0, 0, 0, 0, 0, 24'd0);
        step("midrst", 1, 1, 0, 0, 1, 24'd50);
        check("midrst.pc_out", 32'(pc_out), 0);
        check("midrst.pc_id", 32'(pc_id), 0);
        check("midrst.valid", 32'(valid_id), 0);
        check("midrst.running", 32'(running), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 15),
                 24'($urandom));
            if (m_state == 2 && $urandom_range(0, 9) == 0)
                step("rand_rst", 1, 0, 0, 0, 0, 24'd0);
            if (m_state == 0)
                step("rand_start", 0, 1, 0, 0, 0, 24'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
